sum_sq_radicand: RTL and testbench

- Upstream feeder for the 8-bit combinational integer square-root stage.
- Takes a pair of unsigned 4-bit components (a, b) and serially computes a*a + b*b with a shift-add datapath.
- Saturates the sum to 8 bits and presents it as the radicand over a valid/ready handshake. The sqrt stage then yields the 4-bit Euclidean magnitude.

---
 rtl/sum_sq_radicand.sv | 93 +++++++++
 tb/tb_sum_sq_radicand.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_sq_radicand.sv
// Serial shift-add computation of a*a + b*b, saturated to OUT_W bits and
// handed downstream as a square-root radicand over a valid/ready handshake.
module sum_sq_radicand #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  a,
   input  logic [IN_W-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] radicand,
   output logic             sat
);

   localparam int ACC_W = 2*IN_W + 1;
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_W - 1);
   localparam logic [ACC_W-1:0] MAX_OUT  = ACC_W'({OUT_W{1'b1}});

   if (OUT_W > 2*IN_W + 1) begin : g_badWidth
      $error("sum_sq_radicand: OUT_W must not exceed 2*IN_W+1");
   end

   typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, DONE} state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [IN_W-1:0]    r_opA;
   logic [IN_W-1:0]    r_opB;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_accept;
   logic               w_lastBit;
   logic [IN_W-1:0]    w_curOp;
   logic [ACC_W-1:0]   w_addend;
   logic [ACC_W-1:0]   w_accNext;
   logic               w_satNext;

   assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign out_valid = (r_state == DONE);
   assign w_accept  = in_valid && in_ready;
   assign w_lastBit = (r_cnt == LAST_BIT);

   // One partial product per cycle: the operand shifted by the current bit index.
   assign w_curOp   = (r_state == MUL_B) ? r_opB : r_opA;
   assign w_addend  = w_curOp[r_cnt] ? (ACC_W'(w_curOp) << r_cnt) : '0;
   assign w_accNext = r_acc + w_addend;
   assign w_satNext = (w_accNext > MAX_OUT);

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_stateNext = MUL_A;
         MUL_A:   if (w_lastBit) w_stateNext = MUL_B;
         MUL_B:   if (w_lastBit) w_stateNext = DONE;
         DONE:    if (out_ready) w_stateNext = w_accept ? MUL_A : IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // The accumulator carries over from MUL_A into MUL_B so it ends as a*a + b*b.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_opA    <= '0;
         r_opB    <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         radicand <= '0;
         sat      <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         if (w_accept) begin
            r_opA <= a;
            r_opB <= b;
            r_acc <= '0;
            r_cnt <= '0;
         end else if ((r_state == MUL_A) || (r_state == MUL_B)) begin
            r_acc <= w_accNext;
            r_cnt <= w_lastBit ? '0 : r_cnt + 1'b1;
            if ((r_state == MUL_B) && w_lastBit) begin
               sat      <= w_satNext;
               radicand <= w_satNext ? {OUT_W{1'b1}} : w_accNext[OUT_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_sum_sq_radicand.sv
// Self-checking bench for sum_sq_radicand: a cycle-level reference model plus
// directed vectors with hand-computed radicands.
module tb_sum_sq_radicand;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] radicand;
   logic       sat;

   int compared = 0;
   int mismatched = 0;

   // Reference model: busy countdown after accept, then a held result.
   int mCount = 0;
   bit mValid = 1'b0;
   int mRad = 0;
   int mSat = 0;
   int mPendRad = 0;
   int mPendSat = 0;
   int mSum = 0;
   bit mAccept = 1'b0;

   sum_sq_radicand #(.IN_W(4), .OUT_W(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .radicand(radicand),
      .sat(sat)
   );

   always #5 clk = ~clk;

   function automatic bit modelInReady();
      return ((mCount == 0) && !mValid) || (mValid && (out_ready == 1'b1));
   endfunction

   task automatic compareValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mCount = 0;
         mValid = 1'b0;
         mRad   = 0;
         mSat   = 0;
      end else begin
         mAccept = (in_valid == 1'b1) && modelInReady();
         if (mValid && (out_ready == 1'b1)) mValid = 1'b0;
         if (mCount > 0) begin
            mCount--;
            if (mCount == 0) begin
               mValid = 1'b1;
               mRad   = mPendRad;
               mSat   = mPendSat;
            end
         end
         if (mAccept) begin
            mSum     = int'(a) * int'(a) + int'(b) * int'(b);
            mCount   = 8;
            mPendSat = (mSum > 255) ? 1 : 0;
            mPendRad = (mSum > 255) ? 255 : mSum;
         end
      end
   end

   // Every cycle, all four observable outputs must match the model.
   always @(negedge clk) begin
      if (compared >= 0) begin
         compareValue("out_valid", 32'(out_valid), 32'(mValid));
         compareValue("in_ready", 32'(in_ready), 32'(modelInReady()));
         compareValue("radicand", 32'(radicand), 32'(mRad));
         compareValue("sat", 32'(sat), 32'(mSat));
      end
   end

   task automatic checkOutput(input logic [7:0] expRad, input logic expSat);
      compareValue("lit_out_valid", 32'(out_valid), 32'd1);
      compareValue("lit_radicand", 32'(radicand), 32'(expRad));
      compareValue("lit_sat", 32'(sat), 32'(expSat));
   endtask

   task automatic waitValid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while ((out_valid !== 1'b1) && (n < 30));
   endtask

   task automatic applyStimulus(input logic [3:0] aIn, input logic [3:0] bIn,
                                input logic [7:0] expRad, input logic expSat, input int holdCycles);
      int lat;
      @(posedge clk);
      #2;
      a = aIn;
      b = bIn;
      in_valid = 1'b1;
      out_ready = (holdCycles == 0);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      a = 4'($urandom);
      b = 4'($urandom);
      waitValid(lat);
      compareValue("latency", 32'(lat), 32'd8);
      checkOutput(expRad, expSat);
      if (holdCycles > 0) begin
         repeat (holdCycles) begin
            @(posedge clk);
            #2;
            in_valid = ~in_valid;
            a = 4'($urandom);
            b = 4'($urandom);
         end
         checkOutput(expRad, expSat);
         compareValue("hold_in_ready", 32'(in_ready), 32'd0);
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         compareValue("release_valid", 32'(out_valid), 32'd0);
         compareValue("release_ready", 32'(in_ready), 32'd1);
         compareValue("release_radicand", 32'(radicand), 32'(expRad));
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic runBackToBack();
      logic [3:0] pa [3] = '{4'd1, 4'd7, 4'd9};
      logic [3:0] pb [3] = '{4'd2, 4'd7, 4'd9};
      logic [7:0] pe [3] = '{8'd5, 8'd98, 8'd162};
      int lat;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = pa[0];
      b = pb[0];
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         #2;
         if (k < 2) begin
            a = pa[k+1];
            b = pb[k+1];
         end else begin
            in_valid = 1'b0;
         end
         waitValid(lat);
         compareValue("b2b_latency", 32'(lat), 32'd8);
         checkOutput(pe[k], 1'b0);
         compareValue("b2b_in_ready", 32'(in_ready), 32'd1);
         @(posedge clk);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #20;
      compareValue("reset_out_valid", 32'(out_valid), 32'd0);
      compareValue("reset_radicand", 32'(radicand), 32'd0);
      compareValue("reset_sat", 32'(sat), 32'd0);
      compareValue("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b1;

      $display("[TB] directed vectors");
      applyStimulus(4'd3, 4'd4, 8'd25, 1'b0, 0);
      applyStimulus(4'd11, 4'd11, 8'd242, 1'b0, 0);
      applyStimulus(4'd11, 4'd12, 8'd255, 1'b1, 0);
      applyStimulus(4'd15, 4'd15, 8'd255, 1'b1, 0);
      applyStimulus(4'd0, 4'd0, 8'd0, 1'b0, 0);
      applyStimulus(4'd15, 4'd0, 8'd225, 1'b0, 0);
      applyStimulus(4'd5, 4'd12, 8'd169, 1'b0, 6);

      $display("[TB] back-to-back");
      runBackToBack();

      $display("[TB] reset mid-operation");
      @(posedge clk);
      #2;
      a = 4'd6;
      b = 4'd8;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      compareValue("midreset_out_valid", 32'(out_valid), 32'd0);
      compareValue("midreset_radicand", 32'(radicand), 32'd0);
      compareValue("midreset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         compareValue("post_reset_valid", 32'(out_valid), 32'd0);
      end
      applyStimulus(4'd6, 4'd8, 8'd100, 1'b0, 0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
